// File: rtl/blk_3c0509_if.sv
// blk_3c0509_if: handshake and status bundle between the BIST controllers and the fail collector.
interface blk_3c0509_if #(
    parameter int NUM_CTRL = 4,
    parameter int CNT_W    = 8
);
    localparam int IDX_W = NUM_CTRL > 1 ? $clog2(NUM_CTRL) : 1;
    logic                start;
    logic                clear;
    logic [NUM_CTRL-1:0] ctrl_mask;
    logic [NUM_CTRL-1:0] ctrl_fail;
    logic [NUM_CTRL-1:0] ctrl_done;
    logic                busy;
    logic                all_done;
    logic [NUM_CTRL-1:0] fail_vec;
    logic                any_fail;
    logic                first_fail_vld;
    logic [IDX_W-1:0]    first_fail_idx;
    logic [CNT_W-1:0]    fail_cnt;
    modport master (
        output start, clear, ctrl_mask, ctrl_fail, ctrl_done,
        input  busy, all_done, fail_vec, any_fail, first_fail_vld, first_fail_idx, fail_cnt
    );
    modport slave (
        input  start, clear, ctrl_mask, ctrl_fail, ctrl_done,
        output busy, all_done, fail_vec, any_fail, first_fail_vld, first_fail_idx, fail_cnt
    );
endinterface

// File: rtl/blk_3c0509.sv
// blk_3c0509: N-controller BIST fail/done collector with masking, sticky fails and first-fail capture.
// Define MEMLIBC_BIST_FAIL_CNT_EN to build the saturating fail-cycle counter; otherwise fail_cnt is 0.
module blk_3c0509 #(
    parameter int NUM_CTRL = 4,
    parameter int CNT_W    = 8
) (
    input logic clk,
    input logic rst_n,
    blk_3c0509_if.slave bus
);
    localparam int IDX_W = NUM_CTRL > 1 ? $clog2(NUM_CTRL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [NUM_CTRL-1:0] fail_vec_q, fail_vec_d;
    logic [NUM_CTRL-1:0] done_vec_q, done_vec_d;
    logic                ffv_q, ffv_d;
    logic [IDX_W-1:0]    ffi_q, ffi_d;
    logic [NUM_CTRL-1:0] nf, nd;
    logic [IDX_W-1:0]    low_idx;
    logic                run;

    assign nf  = bus.ctrl_fail & ~bus.ctrl_mask;
    assign nd  = bus.ctrl_done & ~bus.ctrl_mask;
    assign run = state_q == RUN && !bus.clear && !bus.start;

    always_comb begin
        low_idx = '0;
        for (int i = NUM_CTRL - 1; i >= 0; i--)
            if (nf[i]) low_idx = IDX_W'(i);
    end

    always_comb begin
        state_d    = state_q;
        fail_vec_d = fail_vec_q;
        done_vec_d = done_vec_q;
        ffv_d      = ffv_q;
        ffi_d      = ffi_q;
        if (bus.clear || bus.start) begin
            state_d    = bus.clear ? IDLE : RUN;
            fail_vec_d = '0;
            done_vec_d = '0;
            ffv_d      = 1'b0;
            ffi_d      = '0;
        end else if (state_q == RUN) begin
            fail_vec_d = fail_vec_q | nf;
            done_vec_d = done_vec_q | nd;
            ffv_d      = ffv_q | (|nf);
            ffi_d      = (!ffv_q && |nf) ? low_idx : ffi_q;
            state_d    = &(done_vec_d | bus.ctrl_mask) ? DONE : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fail_vec_q <= '0;
            done_vec_q <= '0;
            ffv_q      <= 1'b0;
            ffi_q      <= '0;
        end else begin
            state_q    <= state_d;
            fail_vec_q <= fail_vec_d;
            done_vec_q <= done_vec_d;
            ffv_q      <= ffv_d;
            ffi_q      <= ffi_d;
        end
    end

`ifdef MEMLIBC_BIST_FAIL_CNT_EN
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

    always_comb
        fail_cnt_d = (bus.clear || bus.start) ? '0 :
                     (run && |nf && !(&fail_cnt_q)) ? fail_cnt_q + CNT_W'(1) : fail_cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) fail_cnt_q <= '0;
        else        fail_cnt_q <= fail_cnt_d;

    assign bus.fail_cnt = fail_cnt_q;
`else
    assign bus.fail_cnt = '0;
`endif

    assign bus.busy           = state_q == RUN;
    assign bus.all_done       = state_q == DONE;
    assign bus.fail_vec       = fail_vec_q;
    assign bus.any_fail       = |fail_vec_q;
    assign bus.first_fail_vld = ffv_q;
    assign bus.first_fail_idx = ffi_q;
endmodule

// File: tb/tb_blk_3c0509.sv
// tb_blk_3c0509: scoreboard bench; a driver predicts each cycle's outputs, a monitor pops and compares.
module tb_blk_3c0509;
    localparam int N = 4;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    blk_3c0509_if #(.NUM_CTRL(N), .CNT_W(CW)) bus ();
    blk_3c0509 #(.NUM_CTRL(N), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int tag;
        int busy;
        int all_done;
        int fv;
        int af;
        int ffv;
        int ffi;
        int cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    // reference model: state 0 idle, 1 run, 2 done
    int m_st = 0;
    bit m_fv[N];
    bit m_dv[N];
    bit m_ffv;
    int m_ffi;
    int m_cnt;

    task automatic cmp(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].tag <= cyc) begin
            e = q.pop_front();
            if (e.tag < cyc) cmp("stale_entry", e.tag, cyc);
            else begin
                cmp("busy", int'(bus.busy), e.busy);
                cmp("all_done", int'(bus.all_done), e.all_done);
                cmp("fail_vec", int'(bus.fail_vec), e.fv);
                cmp("any_fail", int'(bus.any_fail), e.af);
                cmp("first_fail_vld", int'(bus.first_fail_vld), e.ffv);
                cmp("first_fail_idx", int'(bus.first_fail_idx), e.ffi);
                cmp("fail_cnt", int'(bus.fail_cnt), e.cnt);
            end
        end
    end

    function automatic void model_clear(input int st);
        m_st = st;
        m_ffv = 0;
        m_ffi = 0;
        m_cnt = 0;
        for (int i = 0; i < N; i++) begin
            m_fv[i] = 0;
            m_dv[i] = 0;
        end
    endfunction

    task automatic step(input bit s, input bit c, input logic [N-1:0] mk, input logic [N-1:0] f, input logic [N-1:0] d);
        exp_t x;
        bit hit;
        bit all_in;
        @(posedge clk);
        #1;
        bus.start = s;
        bus.clear = c;
        bus.ctrl_mask = mk;
        bus.ctrl_fail = f;
        bus.ctrl_done = d;
        if (c) model_clear(0);
        else if (s) model_clear(1);
        else if (m_st == 1) begin
            hit = 0;
            all_in = 1;
            for (int i = 0; i < N; i++) begin
                if (f[i] && !mk[i]) begin
                    m_fv[i] = 1;
                    if (!hit && !m_ffv) m_ffi = i;
                    hit = 1;
                end
                if (d[i] && !mk[i]) m_dv[i] = 1;
                if (!m_dv[i] && !mk[i]) all_in = 0;
            end
            if (hit) begin
                m_ffv = 1;
                m_cnt = m_cnt < CMAX ? m_cnt + 1 : CMAX;
            end
            if (all_in) m_st = 2;
        end
        x.tag = cyc + 1;
        x.busy = m_st == 1;
        x.all_done = m_st == 2;
        x.fv = 0;
        x.af = 0;
        for (int i = 0; i < N; i++) if (m_fv[i]) begin
            x.fv += 1 << i;
            x.af = 1;
        end
        x.ffv = m_ffv;
        x.ffi = m_ffi;
`ifdef MEMLIBC_BIST_FAIL_CNT_EN
        x.cnt = m_cnt;
`else
        x.cnt = 0;
`endif
        q.push_back(x);
    endtask

    task automatic drain();
        @(posedge clk);
        @(negedge clk);
        #1;
        cmp("queue_drained", q.size(), 0);
    endtask

    initial begin
        logic [N-1:0] rmask;
        bus.start = 0;
        bus.clear = 0;
        bus.ctrl_mask = '0;
        bus.ctrl_fail = '0;
        bus.ctrl_done = '0;
        model_clear(0);
        #1;
        cmp("rst_busy", int'(bus.busy), 0);
        cmp("rst_fail_vec", int'(bus.fail_vec), 0);
        cmp("rst_fail_cnt", int'(bus.fail_cnt), 0);
        #22 rst_n = 1;
        // fails and dones are ignored in IDLE
        repeat (4) step(0, 0, 4'h0, 4'hF, 4'hF);
        // clean run: done bits on cycles 2,3,5,7 after start
        step(1, 0, 4'h0, 4'h0, 4'h0);
        for (int j = 1; j <= 8; j++)
            step(0, 0, 4'h0, 4'h0, {j == 7, j == 5, j == 3, j == 2});
        // fail capture
        step(1, 0, 4'h0, 4'h0, 4'h0);
        step(0, 0, 4'h0, 4'b1010, 4'h0);
        step(0, 0, 4'h0, 4'b0001, 4'h0);
        step(0, 0, 4'h0, 4'b0001, 4'h0);
        step(0, 0, 4'h0, 4'h0, 4'hF);
        step(0, 0, 4'h0, 4'hF, 4'hF);
        // masking
        step(1, 0, 4'b0100, 4'h0, 4'h0);
        step(0, 0, 4'b0100, 4'b0100, 4'b1011);
        step(0, 0, 4'b0100, 4'b0100, 4'h0);
        // saturation
        step(1, 0, 4'h0, 4'h0, 4'h0);
        repeat (6) step(0, 0, 4'h0, 4'b0001, 4'h0);
        // all masked: one RUN cycle then DONE
        step(1, 0, 4'hF, 4'h0, 4'h0);
        step(0, 0, 4'hF, 4'hF, 4'h0);
        step(0, 0, 4'hF, 4'h0, 4'h0);
        // clear beats start mid-run
        step(1, 0, 4'h0, 4'h0, 4'h0);
        step(0, 0, 4'h0, 4'b0100, 4'h0);
        step(1, 1, 4'h0, 4'hF, 4'h0);
        step(0, 0, 4'h0, 4'hF, 4'h0);
        // restart after captured fails
        step(1, 0, 4'h0, 4'h0, 4'h0);
        step(0, 0, 4'h0, 4'b1000, 4'h0);
        step(0, 0, 4'h0, 4'b0010, 4'b0001);
        step(1, 0, 4'h0, 4'hF, 4'hF);
        step(0, 0, 4'h0, 4'b0100, 4'h0);
        drain();
        // asynchronous reset mid-cycle
        #2 rst_n = 0;
        #1;
        cmp("async_busy", int'(bus.busy), 0);
        cmp("async_fail_vec", int'(bus.fail_vec), 0);
        cmp("async_any_fail", int'(bus.any_fail), 0);
        cmp("async_ffv", int'(bus.first_fail_vld), 0);
        cmp("async_ffi", int'(bus.first_fail_idx), 0);
        cmp("async_fail_cnt", int'(bus.fail_cnt), 0);
        model_clear(0);
        @(negedge clk);
        rst_n = 1;
        // randomized traffic
        rmask = '0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 15) == 0) rmask = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
            step($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0, rmask,
                 $urandom_range(0, 3) == 0 ? N'($urandom_range(0, 15)) : '0,
                 N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)));
        end
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
